// File: rtl/aq_ifu_ras.sv
// ---------------------------------------------------------------------------
// aq_ifu_ras -- IFU return address stack.
//
// Predicts return targets for the IFU next-PC logic. Pre-decode link
// instructions push their return address and return instructions pop it.
// The speculative stack is updated at fetch time.
//
// Build option: `define AQ_IFU_RAS_RECOVER_EN adds a committed copy of the
// stack. Retire events update that copy, and a flush restores the
// speculative stack from it. Without the macro, a flush empties the
// speculative stack and the retire_* inputs are ignored.
//
// Ports
//   forever_cpuclk       clock
//   cpurst_b             asynchronous active-low reset
//   ipack_ras_upd_en     fetch packet accepted; gates all speculative updates
//   pred_link_vld        pre-decoded link (push)
//   pred_ret_vld         pre-decoded return (pop)
//   ras_push_pc          return address to push
//   rtu_ifu_retire_link  retired link (committed push)
//   rtu_ifu_retire_ret   retired return (committed pop)
//   rtu_ifu_retire_pc    return address of the retired link
//   rtu_ifu_flush        pipeline flush; recover the speculative stack
//   ras_target_pc        top-of-stack return target
//   ras_target_vld       stack non-empty
//   ras_overflow         one-cycle pulse after a push overwrote the oldest entry
// ---------------------------------------------------------------------------
module aq_ifu_ras #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int PC_W  = 40
) (
    input  logic            forever_cpuclk,
    input  logic            cpurst_b,
    input  logic            ipack_ras_upd_en,
    input  logic            pred_link_vld,
    input  logic            pred_ret_vld,
    input  logic [PC_W-1:0] ras_push_pc,
    input  logic            rtu_ifu_retire_link,
    input  logic            rtu_ifu_retire_ret,
    input  logic [PC_W-1:0] rtu_ifu_retire_pc,
    input  logic            rtu_ifu_flush,
    output logic [PC_W-1:0] ras_target_pc,
    output logic            ras_target_vld,
    output logic            ras_overflow
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

    // Result of applying one push/pop/replace event to a (tp, cnt) pair.
    typedef struct packed {
        logic             we;
        logic [PTR_W-1:0] widx;
        logic [PTR_W-1:0] tp;
        logic [PTR_W:0]   cnt;
        logic             ovf;
    } ras_upd_t;

    function automatic logic [PTR_W:0] cnt_inc_sat(input logic [PTR_W:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    // Shared by the speculative and committed stacks.
    // link & ret together replaces the top entry (coroutine), unless the
    // stack is empty, in which case it behaves as a plain push.
    function automatic ras_upd_t ras_rule(input logic             link,
                                          input logic             ret,
                                          input logic [PTR_W-1:0] tp,
                                          input logic [PTR_W:0]   cnt);
        ras_upd_t r;
        r.we   = 1'b0;
        r.widx = tp;
        r.tp   = tp;
        r.cnt  = cnt;
        r.ovf  = 1'b0;
        if (link && (!ret || (cnt == '0))) begin
            r.we   = 1'b1;
            r.widx = tp;
            r.tp   = tp + PTR_ONE;
            r.cnt  = cnt_inc_sat(cnt);
            r.ovf  = (cnt == CNT_MAX);
        end else if (link && ret) begin
            r.we   = 1'b1;
            r.widx = tp - PTR_ONE;
        end else if (ret && (cnt != '0)) begin
            r.tp  = tp - PTR_ONE;
            r.cnt = cnt - CNT_ONE;
        end
        return r;
    endfunction

    logic [PC_W-1:0]  spec_arr     [DEPTH];
    logic [PC_W-1:0]  spec_arr_nxt [DEPTH];
    logic [PTR_W-1:0] spec_tp, spec_tp_nxt;
    logic [PTR_W:0]   spec_cnt, spec_cnt_nxt;
    logic             ovf_nxt;
    ras_upd_t         spec_rule;

    assign spec_rule = ras_rule(ipack_ras_upd_en & pred_link_vld,
                                ipack_ras_upd_en & pred_ret_vld,
                                spec_tp, spec_cnt);

`ifdef AQ_IFU_RAS_RECOVER_EN
    logic [PC_W-1:0]  cmt_arr     [DEPTH];
    logic [PC_W-1:0]  cmt_arr_nxt [DEPTH];
    logic [PTR_W-1:0] cmt_tp;
    logic [PTR_W:0]   cmt_cnt;
    ras_upd_t         cmt_rule;

    assign cmt_rule = ras_rule(rtu_ifu_retire_link, rtu_ifu_retire_ret,
                               cmt_tp, cmt_cnt);

    always_comb begin
        cmt_arr_nxt = cmt_arr;
        if (cmt_rule.we) begin
            cmt_arr_nxt[cmt_rule.widx] = rtu_ifu_retire_pc;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                cmt_arr[i] <= '0;
            end
            cmt_tp  <= '0;
            cmt_cnt <= '0;
        end else begin
            cmt_arr <= cmt_arr_nxt;
            cmt_tp  <= cmt_rule.tp;
            cmt_cnt <= cmt_rule.cnt;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = ^{rtu_ifu_retire_link, rtu_ifu_retire_ret,
                             rtu_ifu_retire_pc};
`endif

    // Flush wins over fetch-side updates. With recovery, the speculative
    // stack takes the committed state including this cycle's retire event.
    always_comb begin
        spec_arr_nxt = spec_arr;
        spec_tp_nxt  = spec_tp;
        spec_cnt_nxt = spec_cnt;
        ovf_nxt      = 1'b0;
        if (rtu_ifu_flush) begin
`ifdef AQ_IFU_RAS_RECOVER_EN
            spec_arr_nxt = cmt_arr_nxt;
            spec_tp_nxt  = cmt_rule.tp;
            spec_cnt_nxt = cmt_rule.cnt;
`else
            spec_tp_nxt  = '0;
            spec_cnt_nxt = '0;
`endif
        end else begin
            if (spec_rule.we) begin
                spec_arr_nxt[spec_rule.widx] = ras_push_pc;
            end
            spec_tp_nxt  = spec_rule.tp;
            spec_cnt_nxt = spec_rule.cnt;
            ovf_nxt      = spec_rule.ovf;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                spec_arr[i] <= '0;
            end
            spec_tp      <= '0;
            spec_cnt     <= '0;
            ras_overflow <= 1'b0;
        end else begin
            spec_arr     <= spec_arr_nxt;
            spec_tp      <= spec_tp_nxt;
            spec_cnt     <= spec_cnt_nxt;
            ras_overflow <= ovf_nxt;
        end
    end

    assign ras_target_pc  = spec_arr[spec_tp - PTR_ONE];
    assign ras_target_vld = (spec_cnt != '0);

endmodule

// File: tb/tb_aq_ifu_ras.sv
module tb_aq_ifu_ras;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int PC_W  = 40;

    logic            forever_cpuclk;
    logic            cpurst_b;
    logic            ipack_ras_upd_en;
    logic            pred_link_vld;
    logic            pred_ret_vld;
    logic [PC_W-1:0] ras_push_pc;
    logic            rtu_ifu_retire_link;
    logic            rtu_ifu_retire_ret;
    logic [PC_W-1:0] rtu_ifu_retire_pc;
    logic            rtu_ifu_flush;
    logic [PC_W-1:0] ras_target_pc;
    logic            ras_target_vld;
    logic            ras_overflow;

    aq_ifu_ras #(.DEPTH(DEPTH), .PTR_W(PTR_W), .PC_W(PC_W)) dut (
        .forever_cpuclk      (forever_cpuclk),
        .cpurst_b            (cpurst_b),
        .ipack_ras_upd_en    (ipack_ras_upd_en),
        .pred_link_vld       (pred_link_vld),
        .pred_ret_vld        (pred_ret_vld),
        .ras_push_pc         (ras_push_pc),
        .rtu_ifu_retire_link (rtu_ifu_retire_link),
        .rtu_ifu_retire_ret  (rtu_ifu_retire_ret),
        .rtu_ifu_retire_pc   (rtu_ifu_retire_pc),
        .rtu_ifu_flush       (rtu_ifu_flush),
        .ras_target_pc       (ras_target_pc),
        .ras_target_vld      (ras_target_vld),
        .ras_overflow        (ras_overflow)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: stacks as queues, back = top of stack.
    logic [PC_W-1:0] sq[$];
    logic [PC_W-1:0] cq[$];
    bit              exp_ovf;

    task automatic chk(input string name, input logic [PC_W-1:0] act,
                       input logic [PC_W-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        exp_ovf = 1'b0;
`ifdef AQ_IFU_RAS_RECOVER_EN
        if (rtu_ifu_retire_link && (!rtu_ifu_retire_ret || cq.size() == 0)) begin
            cq.push_back(rtu_ifu_retire_pc);
            if (cq.size() > DEPTH) void'(cq.pop_front());
        end else if (rtu_ifu_retire_link && rtu_ifu_retire_ret) begin
            cq[cq.size()-1] = rtu_ifu_retire_pc;
        end else if (rtu_ifu_retire_ret && cq.size() != 0) begin
            void'(cq.pop_back());
        end
`endif
        if (rtu_ifu_flush) begin
`ifdef AQ_IFU_RAS_RECOVER_EN
            sq = cq;
`else
            sq.delete();
`endif
        end else if (ipack_ras_upd_en) begin
            if (pred_link_vld && (!pred_ret_vld || sq.size() == 0)) begin
                if (sq.size() == DEPTH) exp_ovf = 1'b1;
                sq.push_back(ras_push_pc);
                if (sq.size() > DEPTH) void'(sq.pop_front());
            end else if (pred_link_vld && pred_ret_vld) begin
                sq[sq.size()-1] = ras_push_pc;
            end else if (pred_ret_vld && sq.size() != 0) begin
                void'(sq.pop_back());
            end
        end
    endtask

    task automatic model_check();
        chk1("model_vld", ras_target_vld, sq.size() != 0);
        if (sq.size() != 0) chk("model_pc", ras_target_pc, sq[sq.size()-1]);
        chk1("model_ovf", ras_overflow, exp_ovf);
    endtask

    // Called at a negative edge: drive, clock, update model, check.
    task automatic step(input bit ue, input bit l, input bit r,
                        input logic [PC_W-1:0] pc, input bit fl,
                        input bit rl, input bit rr, input logic [PC_W-1:0] rpc);
        ipack_ras_upd_en    = ue;
        pred_link_vld       = l;
        pred_ret_vld        = r;
        ras_push_pc         = pc;
        rtu_ifu_flush       = fl;
        rtu_ifu_retire_link = rl;
        rtu_ifu_retire_ret  = rr;
        rtu_ifu_retire_pc   = rpc;
        @(posedge forever_cpuclk);
        model_update();
        @(negedge forever_cpuclk);
        model_check();
    endtask

    task automatic push(input logic [PC_W-1:0] pc);
        step(1, 1, 0, pc, 0, 0, 0, '0);
    endtask

    task automatic pop();
        step(1, 0, 1, '0, 0, 0, 0, '0);
    endtask

    task automatic do_reset();
        cpurst_b            = 1'b0;
        ipack_ras_upd_en    = 1'b0;
        pred_link_vld       = 1'b0;
        pred_ret_vld        = 1'b0;
        ras_push_pc         = '0;
        rtu_ifu_retire_link = 1'b0;
        rtu_ifu_retire_ret  = 1'b0;
        rtu_ifu_retire_pc   = '0;
        rtu_ifu_flush       = 1'b0;
        sq.delete();
        cq.delete();
        exp_ovf = 1'b0;
        repeat (2) @(negedge forever_cpuclk);
        chk1("reset_vld", ras_target_vld, 1'b0);
        chk("reset_pc", ras_target_pc, '0);
        chk1("reset_ovf", ras_overflow, 1'b0);
        cpurst_b = 1'b1;
    endtask

    initial begin
        logic [63:0] rnd;
        bit ue, l, r, fl, rl, rr;

        // Basic push then pop
        do_reset();
        push(40'h80000104);
        chk1("push_vld", ras_target_vld, 1'b1);
        chk("push_pc", ras_target_pc, 40'h80000104);
        pop();
        chk1("pop_vld", ras_target_vld, 1'b0);

        // Overflow and underflow
        do_reset();
        push(40'h100);
        push(40'h200);
        push(40'h300);
        push(40'h400);
        chk1("full_no_ovf", ras_overflow, 1'b0);
        push(40'h500);
        chk1("ovf_pulse", ras_overflow, 1'b1);
        chk("ovf_top", ras_target_pc, 40'h500);
        pop();
        chk1("ovf_pulse_end", ras_overflow, 1'b0);
        chk("pop1_pc", ras_target_pc, 40'h400);
        pop();
        chk("pop2_pc", ras_target_pc, 40'h300);
        pop();
        chk("pop3_pc", ras_target_pc, 40'h200);
        pop();
        chk1("pop4_vld", ras_target_vld, 1'b0);
        pop();
        chk1("underflow_vld", ras_target_vld, 1'b0);
        push(40'h600);
        chk("after_underflow_pc", ras_target_pc, 40'h600);

        // Coroutine replace
        do_reset();
        push(40'h100);
        step(1, 1, 1, 40'h900, 0, 0, 0, '0);
        chk("replace_pc", ras_target_pc, 40'h900);
        chk1("replace_vld", ras_target_vld, 1'b1);
        pop();
        chk1("replace_cnt1", ras_target_vld, 1'b0);

        // Gated by upd_en
        do_reset();
        step(0, 1, 0, 40'h123, 0, 0, 0, '0);
        chk1("upd_en_low_vld", ras_target_vld, 1'b0);

`ifdef AQ_IFU_RAS_RECOVER_EN
        do_reset();
        step(1, 1, 0, 40'h100, 0, 1, 0, 40'h100);
        push(40'h200);
        push(40'h300);
        step(0, 0, 0, '0, 1, 0, 0, '0);
        chk("recover_pc", ras_target_pc, 40'h100);
        chk1("recover_vld", ras_target_vld, 1'b1);
        pop();
        chk1("recover_cnt1", ras_target_vld, 1'b0);

        do_reset();
        step(1, 1, 0, 40'h100, 0, 1, 0, 40'h100);
        push(40'h200);
        push(40'h300);
        step(0, 0, 0, '0, 1, 1, 0, 40'h700);
        chk("recover_retire_pc", ras_target_pc, 40'h700);
        pop();
        chk("recover_retire_2nd", ras_target_pc, 40'h100);
        pop();
        chk1("recover_retire_cnt2", ras_target_vld, 1'b0);
`else
        do_reset();
        push(40'h100);
        push(40'h200);
        step(0, 0, 0, '0, 1, 0, 0, '0);
        chk1("flush_vld", ras_target_vld, 1'b0);
        push(40'h300);
        chk("flush_push_pc", ras_target_pc, 40'h300);
        chk1("flush_push_vld", ras_target_vld, 1'b1);
`endif

        // Randomized traffic checked against the queue model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ue = ($urandom_range(0, 9) < 8);
            l  = ($urandom_range(0, 9) < 5);
            r  = ($urandom_range(0, 9) < 4);
            fl = ($urandom_range(0, 99) < 4);
            rl = ($urandom_range(0, 9) < 3);
            rr = ($urandom_range(0, 9) < 3);
            rnd = {$urandom(), $urandom()};
            ras_push_pc = rnd[PC_W-1:0];
            rnd = {$urandom(), $urandom()};
            step(ue, l, r, ras_push_pc, fl, rl, rr, rnd[PC_W-1:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/aq_ifu_ras.md
Name: aq_ifu_ras

Overview:
- Return address stack (RAS) in the IFU. Consumes the instruction pre-decode prediction outputs: link = push, ret = pop.
- Supplies the predicted return target to the IFU next-PC logic.
- Holds a speculative stack updated at fetch time. An optional committed copy, updated at retire, restores the speculative stack on pipeline flush.

Parameters:
- DEPTH, 4, number of RAS entries (power of 2, 2..16)
- PTR_W, 2, log2(DEPTH)
- PC_W, 40, return address width

Ports:
- forever_cpuclk  input  1  clock
- cpurst_b  input  1  asynchronous active-low reset
- ipack_ras_upd_en  input  1  fetch packet accepted this cycle; gates all speculative updates
- pred_link_vld  input  1  link instruction (push) from pre-decode
- pred_ret_vld  input  1  return instruction (pop) from pre-decode
- ras_push_pc  input  PC_W  return address to push (link instruction PC + 2 or + 4)
- rtu_ifu_retire_link  input  1  retired instruction was a link
- rtu_ifu_retire_ret  input  1  retired instruction was a return
- rtu_ifu_retire_pc  input  PC_W  return address of the retired link
- rtu_ifu_flush  input  1  pipeline flush; recover speculative stack
- ras_target_pc  output  PC_W  top-of-stack return target
- ras_target_vld  output  1  stack non-empty, so the target may be used
- ras_overflow  output  1  one-cycle pulse when a push overwrites the oldest entry

Behaviour:
- Reset (cpurst_b low, asynchronous):
  - speculative and committed pointers = 0; counts = 0; all entries = 0.
  - Outputs: ras_target_vld = 0, ras_target_pc = 0, ras_overflow = 0.
- Storage:
  - Circular array, top pointer tp, count cnt (0..DEPTH).
  - ras_target_pc = entry[tp-1 mod DEPTH], combinational from registers.
  - ras_target_vld = (cnt != 0).
- Push (upd_en & link & !ret):
  - entry[tp] <= ras_push_pc; tp <= tp+1 (wraps mod DEPTH).
  - cnt <= min(cnt+1, DEPTH).
  - If cnt == DEPTH before the push: oldest entry is overwritten and ras_overflow pulses for 1 cycle.
- Pop (upd_en & ret & !link):
  - If cnt != 0: tp <= tp-1 (wraps), cnt <= cnt-1.
  - If cnt == 0: no change (underflow ignored), ras_target_vld stays 0.
- Push and pop in the same cycle (upd_en & link & ret, coroutine):
  - entry[tp-1] <= ras_push_pc; tp and cnt unchanged.
  - If cnt == 0, treated as a plain push.
- upd_en low: pred_link_vld and pred_ret_vld are ignored.
- Latency: every update is visible on ras_target_pc / ras_target_vld the cycle after it.
- Committed stack: the same push/pop/replace rules, driven by the retire_* inputs every cycle, independent of upd_en.
- Flush (rtu_ifu_flush):
  - Highest priority over fetch-side updates in the same cycle.
  - Recovery action is defined by the optional feature.
  - Retire updates in the flush cycle are applied to the committed copy first. The speculative copy receives the post-retire committed state.
- Pointer arithmetic is PTR_W bits with natural wrap. cnt is PTR_W+1 bits and saturates.

Optional Feature:
- Macro: AQ_IFU_RAS_RECOVER_EN.
- Defined:
  - The committed array, tp and cnt are instantiated.
  - On flush, the speculative array, tp and cnt are loaded from the committed copy in one cycle. ras_target_* reflect the restored state the next cycle.
- Undefined:
  - No committed storage; retire_* inputs are unused.
  - On flush, speculative cnt <= 0 and tp <= 0; entries are not cleared.
  - ras_target_vld = 0 the next cycle.

Test Plan:
- Reset, then push 0x80000104 with upd_en=1 → next cycle ras_target_vld=1, ras_target_pc=0x80000104; pop → next cycle ras_target_vld=0.
- Push A=0x100, B=0x200, C=0x300, D=0x400, E=0x500 with DEPTH=4 → ras_overflow pulses on E. Four pops return 0x500, 0x400, 0x300, 0x200; the 5th pop leaves ras_target_vld=0 and the pointer unchanged.
- Push 0x100, then assert link and ret together with ras_push_pc=0x900 → ras_target_pc=0x900, count still 1.
- link=1 with upd_en=0 → no state change; ras_target_vld remains 0.
- With AQ_IFU_RAS_RECOVER_EN:
  - Stimulus: retire_link with pc 0x100; speculative pushes 0x100, 0x200, 0x300; then flush.
  - Required response: next cycle ras_target_pc=0x100, count 1.
  - Retire_link with pc 0x700 in the flush cycle: restored top is 0x700, count 2.
- Without AQ_IFU_RAS_RECOVER_EN: push 0x100, 0x200, then flush → next cycle ras_target_vld=0; a subsequent push of 0x300 gives ras_target_pc=0x300.
